// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
    function automatic booth_op_e recode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_PASS;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_mult_ctrl_if.sv
// Operand request and product response channel of the Booth multiplier sequencer.
interface booth_seq_mult_ctrl_if;
    import booth_pkg::*;

    logic                   start;
    logic                   in_ready;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier, out_ready,
        input  in_ready, busy, out_valid, product
    );

    modport slave (
        input  start, multiplicand, multiplier, out_ready,
        output in_ready, busy, out_valid, product
    );

endinterface

// File: rtl/kogge_stone_adder.sv
// Parallel-prefix (Kogge-Stone) adder with carry-in and carry-out.
module kogge_stone_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int LVLS = $clog2(WIDTH);

    logic [LVLS:0][WIDTH-1:0] g;
    logic [LVLS:0][WIDTH-1:0] p;
    logic [WIDTH:0]           c;

    always_comb begin
        g[0] = a & b;
        p[0] = a ^ b;
        for (int l = 0; l < LVLS; l++) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i >= (1 << l)) begin
                    g[l+1][i] = g[l][i] | (p[l][i] & g[l][i-(1<<l)]);
                    p[l+1][i] = p[l][i] & p[l][i-(1<<l)];
                end else begin
                    g[l+1][i] = g[l][i];
                    p[l+1][i] = p[l][i];
                end
            end
        end
        // Group generate/propagate from bit 0 fold in the carry-in directly.
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[LVLS][i] | (p[LVLS][i] & cin);
        end
    end

    assign sum  = p[0] ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequencer for a 16x16 signed radix-2 Booth multiplier sharing one Kogge-Stone adder.
module booth_seq_mult_ctrl
    import booth_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    booth_seq_mult_ctrl_if.slave  bus
);

    state_e             state;
    logic [WIDTH-1:0]   a_reg, q_reg, m_reg;
    logic               q_1;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] product_reg;
    logic               in_ready_r, busy_r, out_valid_r;

    booth_op_e          op;
    logic [WIDTH-1:0]   add_b, sum;
    logic               add_cin, cout, shift_in;
    logic [WIDTH-1:0]   a_next, q_next;

    assign op = recode(q_reg[0], q_1);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (op)
            OP_ADD: add_b = m_reg;
            OP_SUB: begin
                add_b   = ~m_reg;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    kogge_stone_adder #(.WIDTH(WIDTH)) u_adder (
        .a   (a_reg),
        .b   (add_b),
        .cin (add_cin),
        .sum (sum),
        .cout(cout)
    );

    // Bit 16 of the sign-extended sum; sum[15] would be wrong when subtracting 0x8000.
    assign shift_in = a_reg[WIDTH-1] ^ add_b[WIDTH-1] ^ cout;
    assign a_next   = {shift_in, sum[WIDTH-1:1]};
    assign q_next   = {sum[0], q_reg[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            q_1         <= 1'b0;
            m_reg       <= '0;
            count       <= '0;
            product_reg <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && in_ready_r) begin
                        a_reg      <= '0;
                        q_reg      <= bus.multiplier;
                        q_1        <= 1'b0;
                        m_reg      <= bus.multiplicand;
                        count      <= '0;
                        state      <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    q_1   <= q_reg[0];
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        product_reg <= {a_next, q_next};
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_reg;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Self-checking bench for booth_seq_mult_ctrl against a plain signed-multiply reference.
module tb_booth_seq_mult_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    booth_seq_mult_ctrl_if bus ();

    booth_seq_mult_ctrl dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mult(input logic [15:0] m, input logic [15:0] q);
        int sm, sq;
        sm = $signed(m);
        sq = $signed(q);
        return 32'(sm * sq);
    endfunction

    // Runs one multiply; lat counts edges from the accepting edge (inclusive) to out_valid.
    task automatic run_op(input logic [15:0] m, input logic [15:0] q, input int stall,
                          output logic [31:0] prod, output int lat, output int busy_cyc,
                          output logic exit_ok);
        int n;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.out_ready    = 1'b0;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat       = 1;
        busy_cyc  = bus.busy ? 1 : 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) busy_cyc++;
        end
        prod = bus.product;
        repeat (stall) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        exit_ok = bus.in_ready && !bus.out_valid && !bus.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
            $display("FAIL reset_flags: got in_ready/busy/out_valid=%b expected 100",
                     {bus.in_ready, bus.busy, bus.out_valid});
        end else pass_cnt++;
        total_cnt++;
        if (bus.product !== 32'h0) begin
            $display("FAIL reset_product: got %h expected 00000000", bus.product);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] prod;
        int lat, busy_cyc;
        logic exit_ok;
        run_op(16'd3, 16'd5, 0, prod, lat, busy_cyc, exit_ok);
        total_cnt++;
        if (prod !== 32'h0000000F) $display("FAIL basic_product: got %h expected 0000000f", prod);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 17) $display("FAIL basic_latency: got %0d edges expected 17", lat);
        else pass_cnt++;
        total_cnt++;
        if (busy_cyc !== 16) $display("FAIL basic_busy_cycles: got %0d expected 16", busy_cyc);
        else pass_cnt++;
        total_cnt++;
        if (exit_ok !== 1'b1) $display("FAIL basic_return_idle: got %b expected 1", exit_ok);
        else pass_cnt++;
    endtask

    task automatic test_signed_corners();
        logic [15:0] ms [6] = '{16'hFFF9, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000};
        logic [15:0] qs [6] = '{16'h0006, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8000};
        logic [31:0] want [6] = '{32'hFFFFFFD6, 32'hFFFF8000, 32'h3FFF0001,
                                 32'h40000000, 32'h00008000, 32'h00000000};
        logic [31:0] prod;
        int lat, busy_cyc;
        logic exit_ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ms[i], qs[i], 0, prod, lat, busy_cyc, exit_ok);
            total_cnt++;
            if (prod !== want[i]) begin
                $display("FAIL corner_%0d (%h x %h): got %h expected %h", i, ms[i], qs[i], prod, want[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] want;
        logic [31:0] held;
        int n;
        want = ref_mult(16'h1234, 16'hFF56);
        bus.multiplicand = 16'h1234;
        bus.multiplier   = 16'hFF56;
        bus.out_ready    = 1'b0;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        held = bus.product;
        total_cnt++;
        if (held !== want) $display("FAIL bp_product: got %h expected %h", held, want);
        else pass_cnt++;
        for (int c = 0; c < 5; c++) begin
            bus.start        = 1'b1;
            bus.multiplicand = 16'($urandom);
            bus.multiplier   = 16'($urandom);
            @(posedge clk); #1;
            total_cnt++;
            if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b100 || bus.product !== want) begin
                $display("FAIL bp_hold_%0d: got valid/ready/busy=%b product=%h expected 100 product=%h",
                         c, {bus.out_valid, bus.in_ready, bus.busy}, bus.product, want);
            end else pass_cnt++;
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        total_cnt++;
        if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
            $display("FAIL bp_release: got ready/valid/busy=%b expected 100",
                     {bus.in_ready, bus.out_valid, bus.busy});
        end else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL bp_no_queue: got busy=%b expected 0", bus.busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] prod;
        int lat, busy_cyc;
        logic exit_ok;
        bus.multiplicand = 16'd2;
        bus.multiplier   = 16'd2;
        bus.start        = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total_cnt++;
        if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100 || bus.product !== 32'h0) begin
            $display("FAIL midrun_reset: got ready/busy/valid=%b product=%h expected 100 product=00000000",
                     {bus.in_ready, bus.busy, bus.out_valid}, bus.product);
        end else pass_cnt++;
        run_op(16'd2, 16'd2, 0, prod, lat, busy_cyc, exit_ok);
        total_cnt++;
        if (prod !== 32'h00000004) $display("FAIL midrun_after: got %h expected 00000004", prod);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] m, q;
        logic [31:0] prod, want;
        int lat, busy_cyc;
        logic exit_ok;
        logic [15:0] corner [4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        for (int i = 0; i < 2000; i++) begin
            m = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            q = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
            want = ref_mult(m, q);
            run_op(m, q, $urandom_range(0, 3), prod, lat, busy_cyc, exit_ok);
            total_cnt++;
            if (prod !== want || lat !== 17 || exit_ok !== 1'b1) begin
                $display("FAIL random_%0d (%h x %h): got %h lat=%0d exit=%b expected %h lat=17 exit=1",
                         i, m, q, prod, lat, exit_ok, want);
            end else pass_cnt++;
        end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.out_ready    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        test_reset();
        test_basic();
        test_signed_corners();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
